// File: rtl/variable_clk_multi.sv
// rtl/variable_clk_multi.sv - multi-channel programmable square-wave generator on a shared prescaler
// Optional phase alignment (sync input) is built when VCLK_PHASE_ALIGN_EN is defined.
module variable_clk_multi #(
   parameter int CHANNELS = 2,
   parameter int WIDTH    = 10,
   parameter int PRESCALE = 50000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
`ifdef VCLK_PHASE_ALIGN_EN
   input  logic                      sync,
`endif
   input  logic [CHANNELS*WIDTH-1:0] period_in,
   output logic [CHANNELS-1:0]       clk_out,
   output logic [CHANNELS-1:0]       tick,
   output logic [CHANNELS-1:0]       active
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [PW-1:0] r_pre_cnt;
   logic          w_unit_stb;
   logic          w_sync;

`ifdef VCLK_PHASE_ALIGN_EN
   assign w_sync = sync;
`else
   assign w_sync = 1'b0;
`endif

   assign w_unit_stb = en && (r_pre_cnt == PW'(PRESCALE - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pre_cnt <= '0;
      end else if (w_sync) begin
         r_pre_cnt <= '0;
      end else if (en) begin
         if (w_unit_stb) begin
            r_pre_cnt <= '0;
         end else begin
            r_pre_cnt <= r_pre_cnt + PW'(1);
         end
      end
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      logic [0:0]       r_state;
      logic [WIDTH-1:0] r_cnt;
      logic [WIDTH-1:0] r_per;
      logic             r_clk;
      logic             r_tick;
      logic [WIDTH-1:0] w_req;
      logic             w_bound;

      assign w_req   = period_in[k*WIDTH +: WIDTH];
      // r_per is never zero while in RUN, so per-1 cannot wrap
      assign w_bound = (r_cnt == (r_per - WIDTH'(1)));

      always_ff @(posedge clk) begin
         if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_per   <= '0;
            r_clk   <= 1'b0;
            r_tick  <= 1'b0;
         end else if (w_sync) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_clk   <= 1'b0;
            r_tick  <= 1'b0;
         end else begin
            r_tick <= 1'b0;
            if (w_unit_stb) begin
               case (r_state)
                  ST_IDLE: begin
                     if (w_req != '0) begin
                        r_per   <= w_req;
                        r_cnt   <= '0;
                        r_clk   <= 1'b1;
                        r_tick  <= 1'b1;
                        r_state <= ST_RUN;
                     end
                  end
                  default: begin
                     if (!w_bound) begin
                        r_cnt <= r_cnt + WIDTH'(1);
                     end else begin
                        r_cnt <= '0;
                        if (w_req == '0) begin
                           r_clk   <= 1'b0;
                           r_state <= ST_IDLE;
                        end else begin
                           r_per  <= w_req;
                           r_clk  <= ~r_clk;
                           r_tick <= ~r_clk;
                        end
                     end
                  end
               endcase
            end
         end
      end

      assign clk_out[k] = r_clk;
      assign tick[k]    = r_tick;
      assign active[k]  = (r_state == ST_RUN);
   end

endmodule
